data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: IDLE/BUSY/DONE handshake with a simple
// req/ack bus, byte-lane steering for stores, load extension and bus timeout.

module dmc_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    input  logic [7:0] wd_b,
    input  logic [7:0] wd_h,
    input  logic [7:0] wd_w,
    output logic       be,
    output logic [7:0] wbyte
);
    localparam logic [1:0] L = 2'(LANE);

    always_comb begin
        be    = 1'b1;
        wbyte = wd_w;
        case (size)
            2'b00: begin
                be    = (addr_lo == L);
                wbyte = wd_b;
            end
            2'b01: begin
                be    = (addr_lo[1] == L[1]);
                wbyte = wd_h;
            end
            default: ;
        endcase
    end
endmodule

module data_mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_in,
    input  logic        mem_wr_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        stall_out,
    output logic        done_out,
    output logic        fault_out,
    output logic [31:0] rdata_out,
    output logic        bus_req_out,
    output logic        bus_we_out,
    output logic [31:0] bus_addr_out,
    output logic [3:0]  bus_be_out,
    output logic [31:0] bus_wdata_out,
    input  logic        bus_ack_in,
    input  logic [31:0] bus_rdata_in
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic        store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state, state_nxt;
    req_t        req_q;
    logic [15:0] tmo_cnt;
    logic        tmo_q;
    logic [31:0] rdata_q;

    logic        req_vld, illegal, start, tmo_hit;
    logic [31:0] rd_ext;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [NUM_LANES-1:0]            lane_be;
    logic [NUM_LANES-1:0][VEC_W-1:0] lane_wd;
    logic [NUM_LANES-1:0][VEC_W-1:0] rd_lanes;

    assign req_vld = mem_rd_in | mem_wr_in;
    assign start   = (state == IDLE) && req_vld && !illegal;
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // mem_wr_in wins when both are high, so legality follows the store rules
    always_comb begin
        if (mem_wr_in)
            illegal = funct3_in[2] | (funct3_in[1:0] == 2'b11);
        else
            illegal = (funct3_in == 3'b011) | (funct3_in[2:1] == 2'b11);
        if (funct3_in[1:0] == 2'b01 && addr_in[0])
            illegal = 1'b1;
        if (funct3_in[1:0] == 2'b10 && addr_in[1:0] != 2'b00)
            illegal = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (bus_ack_in || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (start) begin
                req_q   <= '{store: mem_wr_in, funct3: funct3_in, addr: addr_in, wdata: wdata_in};
                tmo_cnt <= '0;
                tmo_q   <= 1'b0;
            end
            if (state == BUSY) begin
                if (bus_ack_in) begin
                    if (!req_q.store) rdata_q <= rd_ext;
                end else if (tmo_hit) begin
                    tmo_q <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
            end
        end
    end

    // Store steering: each lane picks its byte from the replicated store data
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        dmc_lane #(.LANE(l)) u_lane (
            .size    (req_q.funct3[1:0]),
            .addr_lo (req_q.addr[1:0]),
            .wd_b    (req_q.wdata[7:0]),
            .wd_h    (req_q.wdata[VEC_W*(l%2) +: VEC_W]),
            .wd_w    (req_q.wdata[VEC_W*l +: VEC_W]),
            .be      (lane_be[l]),
            .wbyte   (lane_wd[l])
        );
    end

    assign rd_lanes = bus_rdata_in;
    assign rd_byte  = rd_lanes[req_q.addr[1:0]];
    assign rd_half  = req_q.addr[1] ? bus_rdata_in[31:16] : bus_rdata_in[15:0];

    always_comb begin
        case (req_q.funct3)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rd_ext = {24'b0, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  rd_ext = {16'b0, rd_half};
            default: rd_ext = bus_rdata_in;
        endcase
    end

    // IDLE outputs are combinational on the request, so gate them with rst
    always_comb begin
        stall_out     = 1'b0;
        done_out      = 1'b0;
        fault_out     = 1'b0;
        bus_req_out   = 1'b0;
        bus_we_out    = 1'b0;
        bus_addr_out  = '0;
        bus_be_out    = '0;
        bus_wdata_out = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req_vld) begin
                        fault_out = illegal;
                        stall_out = !illegal;
                    end
                end
                BUSY: begin
                    stall_out     = 1'b1;
                    bus_req_out   = 1'b1;
                    bus_we_out    = req_q.store;
                    bus_addr_out  = {req_q.addr[31:2], 2'b00};
                    bus_be_out    = lane_be;
                    bus_wdata_out = req_q.store ? lane_wd : '0;
                end
                DONE: begin
                    done_out  = 1'b1;
                    fault_out = tmo_q;
                end
                default: ;
            endcase
        end
    end

    assign rdata_out = rdata_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl against a per-access behavioural model.
module tb_data_mem_ctrl;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd_in = 1'b0, mem_wr_in = 1'b0;
    logic [2:0]  funct3_in = '0;
    logic [31:0] addr_in = '0, wdata_in = '0;
    logic        stall_out, done_out, fault_out;
    logic [31:0] rdata_out;
    logic        bus_req_out, bus_we_out;
    logic [31:0] bus_addr_out, bus_wdata_out;
    logic [3:0]  bus_be_out;
    logic        bus_ack_in = 1'b0;
    logic [31:0] bus_rdata_in = '0;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] m_rdata = '0;

    data_mem_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
        .funct3_in(funct3_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .stall_out(stall_out), .done_out(done_out), .fault_out(fault_out),
        .rdata_out(rdata_out),
        .bus_req_out(bus_req_out), .bus_we_out(bus_we_out),
        .bus_addr_out(bus_addr_out), .bus_be_out(bus_be_out),
        .bus_wdata_out(bus_wdata_out),
        .bus_ack_in(bus_ack_in), .bus_rdata_in(bus_rdata_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit exp_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (st && f3 > 3'd2) return 0;
        if (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 0;
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 0;
        if (f3 == 3'd2 && a[1:0] != 2'b00) return 0;
        return 1;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        case (f3[1:0])
            2'd0:    return 4'b0001 << a[1:0];
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] b, h;
        b = d >> (8 * a[1:0]);
        h = d >> (16 * a[1]);
        case (f3)
            3'd0:    return {{24{b[7]}}, b[7:0]};
            3'd4:    return {24'b0, b[7:0]};
            3'd1:    return {{16{h[15]}}, h[15:0]};
            3'd5:    return {16'b0, h[15:0]};
            default: return d;
        endcase
    endfunction

    // One access from its IDLE cycle to its DONE cycle; ack after 'waits' BUSY cycles
    task automatic do_access(input bit st, input bit both, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int waits);
        int  stalls;
        bit  acked;
        @(negedge clk);
        mem_wr_in = st; mem_rd_in = !st | both;
        funct3_in = f3; addr_in = a; wdata_in = wd; bus_ack_in = 1'b0;
        #1;
        if (!exp_legal(st, f3, a)) begin
            chk("flt_pulse", 32'(fault_out), 32'd1);
            chk("flt_stall", 32'(stall_out), 32'd0);
            chk("flt_req",   32'(bus_req_out), 32'd0);
            @(negedge clk);
            mem_wr_in = 1'b0; mem_rd_in = 1'b0;
            #1;
            chk("flt_idle", {28'b0, fault_out, stall_out, bus_req_out, done_out}, 32'd0);
            return;
        end
        chk("start_stall", 32'(stall_out), 32'd1);
        chk("start_flt",   32'(fault_out), 32'd0);
        chk("start_req",   32'(bus_req_out), 32'd0);
        stalls = 1;
        acked  = 0;
        for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            mem_wr_in = 1'b0; mem_rd_in = 1'b0;
            addr_in = $urandom; wdata_in = $urandom; funct3_in = 3'($urandom);
            bus_ack_in   = (c == waits);
            bus_rdata_in = (c == waits) ? rd : $urandom;
            #1;
            chk("busy_req",  32'(bus_req_out), 32'd1);
            chk("busy_we",   32'(bus_we_out), 32'(st));
            chk("busy_addr", bus_addr_out, {a[31:2], 2'b00});
            chk("busy_be",   32'(bus_be_out), 32'(exp_be(f3, a)));
            if (st) chk("busy_wdata", bus_wdata_out, exp_wd(f3, wd));
            stalls += int'(stall_out);
            if (bus_ack_in) begin
                acked = 1;
                break;
            end
        end
        @(negedge clk);
        bus_ack_in = 1'($urandom);
        bus_rdata_in = $urandom;
        #1;
        if (acked && !st) m_rdata = exp_ld(f3, a, rd);
        chk("done_pulse", 32'(done_out), 32'd1);
        chk("done_fault", 32'(fault_out), 32'(!acked));
        chk("done_stall", 32'(stall_out), 32'd0);
        chk("done_req",   32'(bus_req_out), 32'd0);
        chk("rdata",      rdata_out, m_rdata);
        chk("stall_cyc",  32'(stalls), acked ? 32'(waits + 2) : 32'(TMO + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // outputs must stay low in reset even with a request present
        mem_rd_in = 1'b1; funct3_in = 3'd3; addr_in = 32'h3;
        #12;
        chk("rst_outs", {25'b0, stall_out, done_out, fault_out, bus_req_out, bus_we_out,
                         |bus_be_out, |bus_addr_out}, 32'd0);
        chk("rst_wdata", bus_wdata_out, 32'd0);
        chk("rst_rdata", rdata_out, 32'd0);
        mem_rd_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        do_access(0, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        do_access(0, 0, 3'd0, 32'h103, 32'h0, 32'h80FFFFFF, 0);
        do_access(0, 0, 3'd4, 32'h103, 32'h0, 32'h80FFFFFF, 1);
        do_access(1, 0, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 0);
        do_access(0, 0, 3'd2, 32'h102, 32'h0, 32'h0, 0);
        do_access(1, 0, 3'd2, 32'h300, 32'hCAFEF00D, 32'h0, TMO + 3);
        do_access(1, 1, 3'd0, 32'h401, 32'h000000A5, 32'h0, 1);

        // reset during BUSY abandons the access and ignores a later ack
        @(negedge clk);
        mem_rd_in = 1'b1; funct3_in = 3'd2; addr_in = 32'h40;
        @(negedge clk);
        mem_rd_in = 1'b0;
        #1;
        chk("pre_rst_req", 32'(bus_req_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        m_rdata = '0;
        chk("mid_rst_req",   32'(bus_req_out), 32'd0);
        chk("mid_rst_stall", 32'(stall_out), 32'd0);
        chk("mid_rst_rdata", rdata_out, m_rdata);
        @(negedge clk);
        rst = 1'b0; bus_ack_in = 1'b1; bus_rdata_in = 32'h12345678;
        #1;
        chk("post_rst_req",  32'(bus_req_out), 32'd0);
        chk("post_rst_done", 32'(done_out), 32'd0);
        @(negedge clk);
        bus_ack_in = 1'b0;
        #1;
        chk("post_rst_done2", 32'(done_out), 32'd0);
        chk("post_rst_rdata", rdata_out, m_rdata);

        for (int i = 0; i < 200; i++) begin
            do_access(1'($urandom), ($urandom % 4) == 0, 3'($urandom), $urandom,
                      $urandom, $urandom, $urandom_range(0, TMO + 1));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
